// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the divide-by-zero result pattern.
package muldiv_pkg;
  typedef logic [2:0] op_t;

  localparam op_t OP_MULT  = 3'd0;
  localparam op_t OP_MULTU = 3'd1;
  localparam op_t OP_DIV   = 3'd2;
  localparam op_t OP_DIVU  = 3'd3;
  localparam op_t OP_MTHI  = 3'd4;
  localparam op_t OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  // Divide by zero: every LO bit takes this value; HI returns the dividend.
  localparam logic DIVZ_LO_BIT = 1'b1;
endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> muldiv handshake: issue strobe, operands, flush, status and HI/LO.
interface muldiv_if #(parameter int WIDTH = 32);
  import muldiv_pkg::*;

  logic             start;
  op_t              op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, src_a, src_b, flush,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, src_a, src_b, flush,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step (mode=0) or
// restoring divide step (mode=1). in_bit is the current multiplier/dividend bit.
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               mode,
  input  logic               in_bit,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               q_bit
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rs;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (in_bit ? {1'b0, operand} : '0);
    rs      = {acc[2*WIDTH-1:WIDTH], in_bit};
    // Only consumed when rs >= operand, so the wrapped low WIDTH bits are exact.
    diff    = rs[WIDTH-1:0] - operand;
    q_bit   = 1'b0;
    acc_nxt = {sum, acc[WIDTH-1:1]};
    if (mode) begin
      q_bit   = (rs >= {1'b0, operand});
      acc_nxt = {(q_bit ? diff : rs[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers. One datapath step
// per cycle in RUN, sign fix-up and HI/LO write in FIX, done pulsed afterwards.
module muldiv_unit
  import muldiv_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  state_t             state;
  logic [CW-1:0]      count;
  logic               is_div, neg_q, neg_r, div0;
  logic [WIDTH-1:0]   orig_a, opnd, sh, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc;
  logic               done_q;

  logic               accept, sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               in_bit, q_bit;
  logic [2*WIDTH-1:0] step_acc, prod;
  logic [WIDTH-1:0]   quo, rem;

  assign accept = (state == IDLE) && bus.start && !bus.flush;
  assign sgn    = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  // Most negative value negates to itself, which is its correct unsigned magnitude.
  assign mag_a  = (sgn && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign mag_b  = (sgn && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

  // Multiply consumes the multiplier LSB first, divide consumes the dividend MSB first.
  assign in_bit = is_div ? sh[WIDTH-1] : sh[0];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .operand (opnd),
    .mode    (is_div),
    .in_bit  (in_bit),
    .acc_nxt (step_acc),
    .q_bit   (q_bit)
  );

  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      orig_a <= '0;
      opnd   <= '0;
      sh     <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          case (bus.op)
            OP_MTHI: hi_q <= bus.src_a;
            OP_MTLO: lo_q <= bus.src_a;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div <= bus.op[1];
              neg_q  <= sgn && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
              neg_r  <= sgn && bus.src_a[WIDTH-1];
              div0   <= bus.op[1] && (bus.src_b == '0);
              orig_a <= bus.src_a;
              opnd   <= bus.op[1] ? mag_b : mag_a;
              sh     <= bus.op[1] ? mag_a : mag_b;
              acc    <= '0;
              count  <= CW'(WIDTH - 1);
              state  <= RUN;
            end
            default: ;
          endcase
        end
        RUN: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            acc <= {step_acc[2*WIDTH-1:1], (is_div ? q_bit : step_acc[0])};
            sh  <= is_div ? (sh << 1) : (sh >> 1);
            if (count == '0) state <= FIX;
            else             count <= count - 1'b1;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!bus.flush) begin
            done_q <= 1'b1;
            if (!is_div) begin
              {hi_q, lo_q} <= prod;
            end else if (div0) begin
              lo_q <= {WIDTH{DIVZ_LO_BIT}};
              hi_q <= orig_a;
            end else begin
              lo_q <= quo;
              hi_q <= rem;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases pinned by literals plus
// randomized ops compared every cycle against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  muldiv_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one op as {hi, lo}.
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sp;
    logic [31:0] q, r;
    case (op)
      3'd0: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      3'd1: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 3'd2) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
        end else begin
          q = a / b;
          r = a % b;
        end
        return {r, q};
      end
    endcase
  endfunction

  // Model: an accepted mul/div keeps the unit busy W+1 cycles, then publishes.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (bus.flush) m_left <= 0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0]; m_done <= 1'b1;
          end
        end
      end else if (bus.start && !bus.flush) begin
        case (bus.op)
          3'd4: m_hi <= bus.src_a;
          3'd5: m_lo <= bus.src_a;
          3'd0, 3'd1, 3'd2, 3'd3: begin
            m_pend <= ref_op(bus.op, bus.src_a, bus.src_b);
            m_left <= W + 1;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(bus.busy), 64'(m_left > 0));
    chk("done", 64'(bus.done), 64'(m_done));
    chk("hi",   64'(bus.hi),   64'(m_hi));
    chk("lo",   64'(bus.lo),   64'(m_lo));
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int nb);
    bit seen = 0;
    nb = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      else if (bus.busy) nb++;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic count_dones(input int cyc, output int nd);
    nd = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb, nd;
    bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(nb);
    chk("multu_busy_cycles", 64'(nb), 64'd33);
    chk("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(bus.lo), 64'h0000_0001);

    issue(3'd0, 32'hFFFF_FFF9, 32'd3);
    wait_done(nb);
    chk("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(bus.lo), 64'hFFFF_FFEB);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);   // presented in the done cycle
    wait_done(nb);
    chk("b2b_busy_cycles", 64'(nb), 64'd33);
    chk("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(nb);
    chk("ovf_lo", 64'(bus.lo), 64'h8000_0000);
    chk("ovf_hi", 64'(bus.hi), 64'h0);
    issue(3'd3, 32'd5, 32'd0);
    wait_done(nb);
    chk("div0_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    chk("div0_hi", 64'(bus.hi), 64'd5);

    issue(3'd4, 32'h1234, 32'd0);
    chk("mthi_hi", 64'(bus.hi), 64'h1234);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    issue(3'd5, 32'h5678, 32'd0);
    chk("mtlo_lo", 64'(bus.lo), 64'h5678);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);

    issue(3'd1, 32'd3, 32'd5);
    repeat (3) @(posedge clk); #1;
    issue(3'd1, 32'd7, 32'd7);           // ignored while busy
    count_dones(45, nd);
    chk("one_done", 64'(nd), 64'd1);
    chk("ignored_lo", 64'(bus.lo), 64'd15);

    issue(3'd4, 32'h1234, 32'd0);
    issue(3'd5, 32'h5678, 32'd0);
    issue(3'd3, 32'd100, 32'd7);
    repeat (8) @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    count_dones(40, nd);
    chk("flush_no_done", 64'(nd), 64'd0);
    chk("flush_hi", 64'(bus.hi), 64'h1234);
    chk("flush_lo", 64'(bus.lo), 64'h5678);
    issue(3'd3, 32'd100, 32'd7);
    wait_done(nb);
    chk("divu_lo", 64'(bus.lo), 64'd14);
    chk("divu_hi", 64'(bus.hi), 64'd2);

    bus.flush = 1'b1;
    issue(3'd4, 32'hDEAD, 32'd0);        // flush in IDLE blocks MTHI
    bus.flush = 1'b0;
    chk("idle_flush_hi", 64'(bus.hi), 64'd2);
    issue(3'd6, 32'd9, 32'd9);
    chk("op6_busy", 64'(bus.busy), 64'd0);

    issue(3'd1, 32'd11, 32'd13);
    repeat (4) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_hi", 64'(bus.hi), 64'd0);
    chk("arst_lo", 64'(bus.lo), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(3'd1, 32'd6, 32'd7);
    wait_done(nb);
    chk("post_rst_lo", 64'(bus.lo), 64'd42);

    for (int n = 0; n < 40; n++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 34)) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        issue(3'($urandom_range(0, 5)), pick(), pick());
      end
      for (int i = 0; i < 50 && m_left > 0; i++) @(negedge clk);
      if (m_left > 0) chk("idle_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
